// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, maximum encoded length,
// length decode function and fetch-supplier state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam int MAX_INSTR_BYTES = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RESP
    } state_t;

    // Returns {len[3:0], valid}; unknown codes decode as a 1-byte invalid instruction.
    function automatic logic [4:0] instr_len(input logic [3:0] icode);
        case (icode)
            IHALT, INOP, IRET:               instr_len = {4'd1, 1'b1};
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:    instr_len = {4'd2, 1'b1};
            IIRMOVQ, IRMMOVQ, IMRMOVQ:       instr_len = {4'd10, 1'b1};
            IJXX, ICALL:                     instr_len = {4'd9, 1'b1};
            default:                         instr_len = {4'd1, 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational length decoder: maps an icode to its encoded byte length
// and reports whether the icode is a defined instruction.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       icode_ok
);

    assign {len, icode_ok} = instr_len(icode);

endmodule

// File: rtl/instr_mem_reader.sv
// Fetch-side supplier: streams an instruction out of a byte-wide, 1-cycle
// latency RAM into an 80-bit window, reading only the bytes the icode needs.
module instr_mem_reader
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [63:0]       req_pc,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [0:79]       rsp_instr,
    output logic [3:0]        rsp_len,
    output logic              rsp_mem_error,
    output logic              rsp_instr_error
);

    state_t                     state, state_next;
    logic [63:0]                pc_q;
    logic [3:0]                 issue_idx, rx_idx, len_q;
    logic [0:79]                instr_q;
    logic [MAX_INSTR_BYTES-1:0] oor_q;
    logic                       mem_err_q, instr_err_q;

    logic [64:0] issue_addr;
    logic        issue_in_range, issue_go, rx_go, rx_keep, rx_last;
    logic [3:0]  len_limit, cur_len, dec_len;
    logic [7:0]  rx_byte;
    logic        dec_ok;

    // Address arithmetic is one bit wider than the PC so a huge PC can never wrap into range.
    assign issue_addr     = {1'b0, pc_q} + 65'(issue_idx);
    assign issue_in_range = issue_addr < 65'(MEM_BYTES);

    // Byte 1 is issued speculatively: the length is unknown until byte 0 has been captured.
    assign len_limit = (rx_idx == 4'd0) ? 4'(MAX_INSTR_BYTES) : len_q;
    assign issue_go  = (state == ST_FETCH) && (issue_idx < len_limit);
    assign rx_go     = (state == ST_FETCH) && (rx_idx < issue_idx);
    assign rx_byte   = oor_q[rx_idx] ? 8'h00 : mem_rd_data;

    y86_instr_len u_len (
        .icode    (rx_byte[7:4]),
        .len      (dec_len),
        .icode_ok (dec_ok)
    );

    assign cur_len = (rx_idx == 4'd0) ? dec_len : len_q;
    assign rx_keep = rx_idx < cur_len;
    assign rx_last = rx_go && (rx_idx == 4'(cur_len - 4'd1));

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (issue_go && issue_in_range) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = issue_addr[ADDR_W-1:0];
                end
                if (rx_last) state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the instruction buffer is reset explicitly because its contents are visible on rsp_instr.
            state       <= ST_IDLE;
            pc_q        <= '0;
            issue_idx   <= '0;
            rx_idx      <= '0;
            len_q       <= '0;
            instr_q     <= '0;
            oor_q       <= '0;
            mem_err_q   <= 1'b0;
            instr_err_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        pc_q        <= req_pc;
                        issue_idx   <= '0;
                        rx_idx      <= '0;
                        len_q       <= '0;
                        instr_q     <= '0;
                        oor_q       <= '0;
                        mem_err_q   <= 1'b0;
                        instr_err_q <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (issue_go) begin
                        if (!issue_in_range) oor_q[issue_idx] <= 1'b1;
                        issue_idx <= issue_idx + 4'd1;
                    end
                    if (rx_go) begin
                        if (rx_keep) begin
                            instr_q[8*int'(rx_idx) +: 8] <= rx_byte;
                            if (oor_q[rx_idx]) mem_err_q <= 1'b1;
                        end
                        if (rx_idx == 4'd0) begin
                            len_q       <= dec_len;
                            instr_err_q <= !dec_ok;
                        end
                        rx_idx <= rx_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid       = (state == ST_RESP);
    assign rsp_instr       = instr_q;
    assign rsp_len         = len_q;
    assign rsp_mem_error   = mem_err_q;
    assign rsp_instr_error = instr_err_q;

endmodule

// File: tb/tb_instr_mem_reader.sv
// Self-checking bench for instr_mem_reader: a 1-cycle-latency RAM model plus a
// byte-level reference model of what the fetch window should contain.
module tb_instr_mem_reader;

    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [63:0]       req_pc = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [0:79]       rsp_instr;
    logic [3:0]        rsp_len;
    logic              rsp_mem_error;
    logic              rsp_instr_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:MEM_BYTES-1];
    int rd_count  = 0;
    int rd_stray  = 0;

    instr_mem_reader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_pc          (req_pc),
        .mem_rd_en       (mem_rd_en),
        .mem_addr        (mem_addr),
        .mem_rd_data     (mem_rd_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_instr       (rsp_instr),
        .rsp_len         (rsp_len),
        .rsp_mem_error   (rsp_mem_error),
        .rsp_instr_error (rsp_instr_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    // Read strobes counted mid-cycle; any strobe while idle or responding is stray.
    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_count = rd_count + 1;
            if (req_ready || rsp_valid) rd_stray = rd_stray + 1;
        end
    end

    // Reference model: byte k is mem[pc+k] when in range, else 0; only len bytes kept.
    function automatic void model(input logic [63:0] pc, output logic [0:79] instr,
                                  output logic [3:0] len, output logic merr,
                                  output logic ierr, output int reads);
        logic [7:0] b;
        logic [3:0] icode;
        int issued;
        b     = (pc < 64'(MEM_BYTES)) ? mem[pc[ADDR_W-1:0]] : 8'h00;
        icode = b[7:4];
        ierr  = icode > 4'hB;
        if (icode == 4'h3 || icode == 4'h4 || icode == 4'h5) len = 4'd10;
        else if (icode == 4'h7 || icode == 4'h8) len = 4'd9;
        else if (icode == 4'h2 || icode == 4'h6 || icode == 4'hA || icode == 4'hB) len = 4'd2;
        else len = 4'd1;
        instr = '0;
        merr  = 1'b0;
        for (int k = 0; k < int'(len); k++) begin
            if (pc + 64'(k) < 64'(MEM_BYTES)) instr[8*k +: 8] = mem[ADDR_W'(pc + 64'(k))];
            else merr = 1'b1;
        end
        issued = (len == 4'd1) ? 2 : int'(len);
        reads  = 0;
        for (int k = 0; k < issued; k++)
            if (pc + 64'(k) < 64'(MEM_BYTES)) reads++;
    endfunction

    // One request/response transaction; reports what the DUT produced.
    task automatic run_req(input logic [63:0] pc, input int hold, output logic accepted,
                           output int lat, output logic [0:79] instr, output logic [3:0] len,
                           output logic merr, output logic ierr, output int unstable,
                           output int reads, output int stray);
        @(negedge clk);
        rd_count  = 0;
        rd_stray  = 0;
        req_pc    = pc;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        accepted  = req_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        instr    = rsp_instr;
        len      = rsp_len;
        merr     = rsp_mem_error;
        ierr     = rsp_instr_error;
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (!rsp_valid || req_ready || rsp_instr !== instr || rsp_len !== len ||
                rsp_mem_error !== merr || rsp_instr_error !== ierr) unstable++;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        if (rsp_valid) unstable++;
        reads = rd_count;
        stray = rd_stray;
    endtask

    // Runs a request and compares every observable against the model.
    task automatic check_req(input string name, input logic [63:0] pc, input int hold);
        logic acc, merr, ierr, e_merr, e_ierr;
        logic [0:79] instr, e_instr;
        logic [3:0] len, e_len;
        int lat, unstable, reads, stray, e_reads;
        model(pc, e_instr, e_len, e_merr, e_ierr, e_reads);
        run_req(pc, hold, acc, lat, instr, len, merr, ierr, unstable, reads, stray);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL %s accept: req_ready=%b want 1", name, acc); end
        checks++;
        if (lat !== int'(e_len) + 1) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, int'(e_len) + 1); end
        checks++;
        if (instr !== e_instr) begin errors++; $display("FAIL %s instr: got %h want %h", name, instr, e_instr); end
        checks++;
        if (len !== e_len) begin errors++; $display("FAIL %s len: got %0d want %0d", name, len, e_len); end
        checks++;
        if (merr !== e_merr) begin errors++; $display("FAIL %s mem_error: got %b want %b", name, merr, e_merr); end
        checks++;
        if (ierr !== e_ierr) begin errors++; $display("FAIL %s instr_error: got %b want %b", name, ierr, e_ierr); end
        checks++;
        if (reads !== e_reads) begin errors++; $display("FAIL %s reads: got %0d want %0d", name, reads, e_reads); end
        checks++;
        if (stray !== 0 || unstable !== 0) begin errors++; $display("FAIL %s hold/stray: unstable=%0d stray=%0d want 0", name, unstable, stray); end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== '0 ||
            rsp_instr !== '0 || rsp_len !== 4'd0 || rsp_mem_error !== 1'b0 || rsp_instr_error !== 1'b0) begin
            errors++;
            $display("FAIL %s: rdy=%b vld=%b rd=%b addr=%0d instr=%h len=%0d me=%b ie=%b want 1 0 0 0 0 0 0 0",
                     name, req_ready, rsp_valid, mem_rd_en, mem_addr, rsp_instr, rsp_len,
                     rsp_mem_error, rsp_instr_error);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");
    endtask

    task automatic test_irmovq();
        logic acc, merr, ierr;
        logic [0:79] instr;
        logic [3:0] len;
        int lat, unstable, reads, stray;
        logic [79:0] lit;
        lit = 80'h30F30A00000000000000;
        for (int k = 0; k < 10; k++) mem[k] = lit[79-8*k -: 8];
        run_req(64'd0, 0, acc, lat, instr, len, merr, ierr, unstable, reads, stray);
        checks++;
        if (instr !== lit || len !== 4'd10 || merr || ierr || lat !== 11) begin
            errors++;
            $display("FAIL irmovq: instr=%h len=%0d me=%b ie=%b lat=%0d want %h 10 0 0 11",
                     instr, len, merr, ierr, lat, lit);
        end
        check_req("irmovq_model", 64'd0, 0);
    endtask

    task automatic test_addq();
        mem[32] = 8'h60;
        mem[33] = 8'h23;
        mem[34] = 8'h77;
        check_req("addq", 64'h20, 1);
    endtask

    task automatic test_ret_speculative();
        mem[16] = 8'h90;
        mem[17] = 8'hAB;
        check_req("ret", 64'h10, 0);
    endtask

    task automatic test_jmp_edge();
        mem[1020] = 8'h70;
        mem[1021] = 8'h11;
        mem[1022] = 8'h22;
        mem[1023] = 8'h33;
        check_req("jmp_edge", 64'd1020, 0);
    endtask

    task automatic test_pc_out_of_range();
        check_req("pc_oor", 64'd2000, 0);
        check_req("pc_huge", 64'hFFFF_FFFF_FFFF_FFFE, 0);
    endtask

    task automatic test_bad_icode();
        mem[100] = 8'hE0;
        mem[101] = 8'h55;
        check_req("bad_icode", 64'd100, 0);
    endtask

    task automatic test_hold();
        for (int k = 0; k < 10; k++) mem[200 + k] = 8'(8'h80 + k);
        check_req("hold", 64'd200, 5);
    endtask

    task automatic test_reset_mid_fetch();
        for (int k = 0; k < 10; k++) mem[300 + k] = (k == 0) ? 8'h40 : 8'($urandom);
        @(negedge clk);
        req_pc    = 64'd300;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_fetch");
        @(negedge clk);
        rst = 1'b0;
        check_req("after_reset", 64'd300, 0);
    endtask

    task automatic test_random();
        logic [63:0] pc;
        for (int it = 0; it < 40; it++) begin
            pc = 64'($urandom_range(0, 1040));
            for (int k = 0; k < 10; k++)
                if (pc + 64'(k) < 64'(MEM_BYTES)) mem[ADDR_W'(pc + 64'(k))] = 8'($urandom);
            check_req("random", pc, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        test_reset();
        test_irmovq();
        test_addq();
        test_ret_speculative();
        test_jmp_edge();
        test_pc_out_of_range();
        test_bad_icode();
        test_hold();
        test_reset_mid_fetch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
